// File: rtl/axim_rx_scheduler_if.sv
// Bundle between the accelerator front end, the round-robin scheduler and
// the four HP AXI read engines.
interface axim_rx_scheduler_if #(
  parameter int ADDR_W = 32,
  parameter int SIZE_W = 10
);
  logic              rx_req;
  logic [ADDR_W-1:0] rx_addr;
  logic [SIZE_W-1:0] rx_size;
  logic              rx_ready;
  logic              rx_done;
  logic              err;
  logic [3:0]        hp_rx_req;
  logic [ADDR_W-1:0] hp_rx_addr [4];
  logic [SIZE_W-1:0] hp_rx_size [4];
  logic [3:0]        hp_rx_done;

  modport slave (
    input  rx_req, rx_addr, rx_size, hp_rx_done,
    output rx_ready, rx_done, err, hp_rx_req, hp_rx_addr, hp_rx_size
  );

  modport master (
    output rx_req, rx_addr, rx_size, hp_rx_done,
    input  rx_ready, rx_done, err, hp_rx_req, hp_rx_addr, hp_rx_size
  );
endinterface

// File: rtl/axim_rx_scheduler.sv
// Splits one accelerator read request into fixed-size chunks and deals them
// strictly round-robin to four HP AXI read ports, tracking per-port completion.
module axim_rx_scheduler #(
  parameter int ADDR_W       = 32,
  parameter int SIZE_W       = 10,
  parameter int CHUNK_BURSTS = 4,
  parameter int BURST_BYTES  = 128
) (
  input  logic               clk,
  input  logic               reset,
  axim_rx_scheduler_if.slave bus
);
  // state | meaning
  // IDLE  | accepting a new request (rx_ready high)
  // ISSUE | dealing chunks to ports 0,1,2,3,0,... in order
  // WAIT  | all chunks issued, waiting for outstanding ports
  // DONE  | completion pulse on rx_done
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [SIZE_W-1:0] CHUNK_S = SIZE_W'(CHUNK_BURSTS);
  localparam logic [ADDR_W-1:0] BURST_A = ADDR_W'(BURST_BYTES);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [SIZE_W-1:0] remaining_q, remaining_d;
  logic [1:0]        next_port_q, next_port_d;
  logic [3:0]        busy_q, busy_d;
  logic              rx_ready_q, rx_ready_d;
  logic              rx_done_q, rx_done_d;
  logic              err_q, err_d;
  logic [3:0]        hp_req_q, hp_req_d;
  logic [ADDR_W-1:0] hp_addr_q [4];
  logic [ADDR_W-1:0] hp_addr_d [4];
  logic [SIZE_W-1:0] hp_size_q [4];
  logic [SIZE_W-1:0] hp_size_d [4];
  logic [SIZE_W-1:0] chunk;

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    next_port_d = next_port_q;
    busy_d      = busy_q & ~bus.hp_rx_done;
    err_d       = err_q | (|(bus.hp_rx_done & ~busy_q));
    rx_done_d   = 1'b0;
    hp_req_d    = '0;
    hp_addr_d   = hp_addr_q;
    hp_size_d   = hp_size_q;
    chunk       = (remaining_q < CHUNK_S) ? remaining_q : CHUNK_S;

    case (state_q)
      S_IDLE: begin
        if (bus.rx_req) begin
          if (bus.rx_size != '0) begin
            cur_addr_d  = bus.rx_addr;
            remaining_d = bus.rx_size;
            next_port_d = 2'd0;
            state_d     = S_ISSUE;
          end else begin
            rx_done_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (remaining_q == '0) begin
          state_d = S_WAIT;
        end else if (!busy_q[next_port_q]) begin
          // Strict order: a busy target port stalls issue rather than being skipped.
          hp_req_d[next_port_q]  = 1'b1;
          hp_addr_d[next_port_q] = cur_addr_q;
          hp_size_d[next_port_q] = chunk;
          busy_d[next_port_q]    = 1'b1;
          cur_addr_d             = cur_addr_q + ADDR_W'(chunk) * BURST_A;
          remaining_d            = remaining_q - chunk;
          next_port_d            = next_port_q + 2'd1;
        end
      end
      S_WAIT: begin
        if (busy_q == 4'b0000) begin
          state_d   = S_DONE;
          rx_done_d = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    rx_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      next_port_q <= 2'd0;
      busy_q      <= 4'b0000;
      rx_ready_q  <= 1'b1;
      rx_done_q   <= 1'b0;
      err_q       <= 1'b0;
      hp_req_q    <= 4'b0000;
      hp_addr_q   <= '{default: '0};
      hp_size_q   <= '{default: '0};
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      next_port_q <= next_port_d;
      busy_q      <= busy_d;
      rx_ready_q  <= rx_ready_d;
      rx_done_q   <= rx_done_d;
      err_q       <= err_d;
      hp_req_q    <= hp_req_d;
      hp_addr_q   <= hp_addr_d;
      hp_size_q   <= hp_size_d;
    end
  end

  assign bus.rx_ready   = rx_ready_q;
  assign bus.rx_done    = rx_done_q;
  assign bus.err        = err_q;
  assign bus.hp_rx_req  = hp_req_q;
  assign bus.hp_rx_addr = hp_addr_q;
  assign bus.hp_rx_size = hp_size_q;
endmodule

// File: tb/tb_axim_rx_scheduler.sv
// Directed bench for axim_rx_scheduler: hand-computed chunk addresses, sizes,
// request timing, completion pulse, error flag and reset abort.
module tb_axim_rx_scheduler;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;
  int   req_cnt [4] = '{0, 0, 0, 0};
  int   d0;
  int   r3;

  axim_rx_scheduler_if #(.ADDR_W(32), .SIZE_W(10)) bus ();

  axim_rx_scheduler #(
    .ADDR_W(32), .SIZE_W(10), .CHUNK_BURSTS(4), .BURST_BYTES(128)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.rx_done) done_cnt++;
      for (int p = 0; p < 4; p++) if (bus.hp_rx_req[p]) req_cnt[p]++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [31:0] addr, input logic [9:0] size);
    bus.rx_req  = 1'b1;
    bus.rx_addr = addr;
    bus.rx_size = size;
    tick();
    bus.rx_req = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    bus.rx_req     = 1'b0;
    bus.rx_addr    = '0;
    bus.rx_size    = '0;
    bus.hp_rx_done = 4'b0000;
    tick();
    tick();
    chk("rst_ready", {31'd0, bus.rx_ready}, 32'd1);
    chk("rst_done",  {31'd0, bus.rx_done},  32'd0);
    chk("rst_err",   {31'd0, bus.err},      32'd0);
    chk("rst_req",   {28'd0, bus.hp_rx_req}, 32'd0);
    chk("rst_addr3", bus.hp_rx_addr[3], 32'd0);
    chk("rst_size2", {22'd0, bus.hp_rx_size[2]}, 32'd0);
    reset = 1'b0;
    tick();

    // 16 bursts at 0x1000, each port answers 3 cycles after its request
    d0 = done_cnt;
    start(32'h1000, 10'd16);
    chk("t1_busy_ready", {31'd0, bus.rx_ready}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i < 4) begin
        chk("t1_req",  {28'd0, bus.hp_rx_req}, 32'd1 << i);
        chk("t1_addr", bus.hp_rx_addr[i], 32'h1000 + 32'h200 * i);
        chk("t1_size", {22'd0, bus.hp_rx_size[i]}, 32'd4);
      end
      bus.hp_rx_done = (i >= 3 && i < 7) ? 4'(1 << (i - 3)) : 4'b0000;
    end
    chk("t1_no_early_done", {31'd0, bus.rx_done}, 32'd0);
    tick();
    chk("t1_done", {31'd0, bus.rx_done}, 32'd1);
    chk("t1_ready_low_in_done", {31'd0, bus.rx_ready}, 32'd0);
    tick();
    chk("t1_done_1cyc", {31'd0, bus.rx_done}, 32'd0);
    chk("t1_ready", {31'd0, bus.rx_ready}, 32'd1);
    chk("t1_err", {31'd0, bus.err}, 32'd0);
    chk("t1_done_cnt", done_cnt - d0, 32'd1);

    // 10 bursts at 0: 4,4,2 on hp0..hp2, hp3 never used
    d0 = done_cnt;
    r3 = req_cnt[3];
    start(32'h0, 10'd10);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i < 3) begin
        chk("t2_req",  {28'd0, bus.hp_rx_req}, 32'd1 << i);
        chk("t2_addr", bus.hp_rx_addr[i], 32'h200 * i);
        chk("t2_size", {22'd0, bus.hp_rx_size[i]}, (i == 2) ? 32'd2 : 32'd4);
      end else begin
        chk("t2_req_idle", {28'd0, bus.hp_rx_req}, 32'd0);
      end
      bus.hp_rx_done = (i < 3) ? 4'(1 << i) : 4'b0000;
    end
    tick();
    chk("t2_done", {31'd0, bus.rx_done}, 32'd1);
    tick();
    chk("t2_hp3_unused", req_cnt[3] - r3, 32'd0);
    chk("t2_done_cnt", done_cnt - d0, 32'd1);

    // 20 bursts at 0x2000 with hp0 held off; fifth chunk waits for hp0
    d0 = done_cnt;
    start(32'h2000, 10'd20);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_req",  {28'd0, bus.hp_rx_req}, 32'd1 << i);
      chk("t3_addr", bus.hp_rx_addr[i], 32'h2000 + 32'h200 * i);
      bus.hp_rx_done = (i >= 1) ? 4'(1 << i) : 4'b0000;
    end
    for (int j = 0; j < 16; j++) begin
      tick();
      bus.hp_rx_done = 4'b0000;
      chk("t3_stall", {28'd0, bus.hp_rx_req}, 32'd0);
    end
    tick();
    chk("t3_stall_last", {28'd0, bus.hp_rx_req}, 32'd0);
    bus.hp_rx_done = 4'b0001;
    tick();
    bus.hp_rx_done = 4'b0000;
    chk("t3_not_yet", {28'd0, bus.hp_rx_req}, 32'd0);
    tick();
    chk("t3_req5",  {28'd0, bus.hp_rx_req}, 32'd1);
    chk("t3_addr5", bus.hp_rx_addr[0], 32'h2800);
    chk("t3_size5", {22'd0, bus.hp_rx_size[0]}, 32'd4);
    bus.hp_rx_done = 4'b0001;
    tick();
    bus.hp_rx_done = 4'b0000;
    chk("t3_no_early_done", {31'd0, bus.rx_done}, 32'd0);
    tick();
    chk("t3_done", {31'd0, bus.rx_done}, 32'd1);
    tick();
    chk("t3_done_cnt", done_cnt - d0, 32'd1);

    // zero size completes at once; rx_req while busy is ignored
    d0 = done_cnt;
    start(32'h5000, 10'd0);
    chk("t4_zero_done", {31'd0, bus.rx_done}, 32'd1);
    chk("t4_zero_req",  {28'd0, bus.hp_rx_req}, 32'd0);
    chk("t4_zero_ready", {31'd0, bus.rx_ready}, 32'd1);
    start(32'h3000, 10'd4);
    bus.rx_req  = 1'b1;
    bus.rx_addr = 32'h9000;
    bus.rx_size = 10'd8;
    tick();
    chk("t4_req0",  {28'd0, bus.hp_rx_req}, 32'd1);
    chk("t4_addr0", bus.hp_rx_addr[0], 32'h3000);
    chk("t4_ready_low", {31'd0, bus.rx_ready}, 32'd0);
    bus.hp_rx_done = 4'b0001;
    tick();
    bus.hp_rx_done = 4'b0000;
    chk("t4_ignored_a", {28'd0, bus.hp_rx_req}, 32'd0);
    tick();
    chk("t4_ignored_b", {28'd0, bus.hp_rx_req}, 32'd0);
    chk("t4_done", {31'd0, bus.rx_done}, 32'd1);
    bus.rx_req = 1'b0;
    tick();
    tick();
    tick();
    chk("t4_no_new_req", {28'd0, bus.hp_rx_req}, 32'd0);
    chk("t4_done_cnt", done_cnt - d0, 32'd2);

    // address wrap across 2^32
    d0 = done_cnt;
    start(32'hFFFF_FF00, 10'd8);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t5_req", {28'd0, bus.hp_rx_req}, 32'd1 << i);
      bus.hp_rx_done = 4'(1 << i);
    end
    chk("t5_addr0", bus.hp_rx_addr[0], 32'hFFFF_FF00);
    chk("t5_addr1", bus.hp_rx_addr[1], 32'h0000_0100);
    tick();
    bus.hp_rx_done = 4'b0000;
    tick();
    chk("t5_done", {31'd0, bus.rx_done}, 32'd1);
    chk("t5_err", {31'd0, bus.err}, 32'd0);
    tick();

    // spurious done while idle
    bus.hp_rx_done = 4'b0100;
    tick();
    bus.hp_rx_done = 4'b0000;
    chk("t6_err_set", {31'd0, bus.err}, 32'd1);
    tick();
    tick();
    chk("t6_err_sticky", {31'd0, bus.err}, 32'd1);

    // reset during WAIT aborts the job
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("t7_err_cleared", {31'd0, bus.err}, 32'd0);
    d0 = done_cnt;
    start(32'h4000, 10'd8);
    tick();
    tick();
    chk("t7_req1", {28'd0, bus.hp_rx_req}, 32'd2);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("t7_rst_addr0", bus.hp_rx_addr[0], 32'd0);
    chk("t7_rst_size1", {22'd0, bus.hp_rx_size[1]}, 32'd0);
    chk("t7_rst_ready", {31'd0, bus.rx_ready}, 32'd1);
    tick();
    reset = 1'b0;
    bus.hp_rx_done = 4'b0001;
    tick();
    bus.hp_rx_done = 4'b0000;
    chk("t7_late_err", {31'd0, bus.err}, 32'd1);
    for (int k = 0; k < 6; k++) tick();
    chk("t7_no_done", done_cnt - d0, 32'd0);
    chk("t7_no_req",  {28'd0, bus.hp_rx_req}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
